// File: rtl/item_memory_multiport_top.sv
// Multi-channel item memory front end: per-channel projection/CIM/bypass feeding a hold FIFO.
// Optional stall-cycle counter enabled by defining IM_STALL_COUNTER_EN.
module item_memory_multiport_top #(
  parameter int unsigned HVDimension   = 512,
  parameter int unsigned NumTotIm      = 1024,
  parameter int unsigned NumPerImBank  = 128,
  parameter int unsigned SeedWidth     = 32,
  parameter int unsigned NumPorts      = 4,
  parameter int unsigned HoldFifoDepth = 4,
  parameter int unsigned EnableRomIM   = 0,
  localparam int unsigned ImAddrWidth  = $clog2(NumTotIm),
  localparam int unsigned NumImSets    = NumTotIm / NumPerImBank,
  localparam int unsigned CntWidth     = $clog2(HoldFifoDepth + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumPorts-1:0][1:0]              port_mode_i,
  input  logic [SeedWidth-1:0]                  cim_seed_hv_i,
  input  logic [NumImSets-1:0][SeedWidth-1:0]   im_seed_hv_i,
  input  logic                                  clr_i,
  input  logic                                  enable_i,
  output logic                                  stall_o,
  input  logic [NumPorts-1:0][ImAddrWidth-1:0]  lowdim_data_i,
  input  logic [NumPorts-1:0][HVDimension-1:0]  highdim_data_i,
  input  logic [NumPorts-1:0]                   im_data_valid_i,
  output logic [NumPorts-1:0]                   im_data_ready_o,
  output logic [NumPorts-1:0][HVDimension-1:0]  im_o,
  output logic [NumPorts-1:0]                   im_valid_o,
  input  logic [NumPorts-1:0]                   im_pop_i,
  output logic [NumPorts-1:0][CntWidth-1:0]     fifo_count_o,
  output logic [31:0]                           stall_cnt_o
);

  localparam int unsigned PtrWidth  = $clog2(HoldFifoDepth);
  localparam int unsigned NumChunks = HVDimension / SeedWidth;

  // Hardwired seed pattern used when the item memory is a ROM.
  function automatic logic [SeedWidth-1:0] rom_seed(int unsigned set);
    logic [SeedWidth-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < SeedWidth; i++) begin
      s = (s << 1) | SeedWidth'((((i + 1) * (set + 3)) % 7) < 3);
    end
    return s;
  endfunction

  // Entry = bank seed replicated; chunk j is rotated left by (index-in-bank + j).
  function automatic logic [HVDimension-1:0] project_hv(
      logic [ImAddrWidth-1:0] addr, logic [NumImSets-1:0][SeedWidth-1:0] seeds);
    int unsigned          set, idx;
    logic [SeedWidth-1:0] seed;
    logic [2*SeedWidth-1:0] dbl;
    logic [HVDimension-1:0] hv;
    set = 32'(addr) / NumPerImBank;
    idx = 32'(addr) % NumPerImBank;
    if (set >= NumImSets) set = NumImSets - 1;
    seed = '0;
    for (int unsigned s = 0; s < NumImSets; s++) begin
      if (s == set) seed = (EnableRomIM != 0) ? rom_seed(s) : seeds[s];
    end
    hv = '0;
    for (int j = int'(NumChunks) - 1; j >= 0; j--) begin
      dbl = {seed, seed} << ((idx + 32'(j)) % SeedWidth);
      hv  = (hv << SeedWidth) | HVDimension'(dbl[2*SeedWidth-1:SeedWidth]);
    end
    return hv;
  endfunction

  // Continuous item memory: replicated seed with the low addr*D/(2*N) bits flipped.
  function automatic logic [HVDimension-1:0] cim_hv(
      logic [ImAddrWidth-1:0] addr, logic [SeedWidth-1:0] seed);
    logic [HVDimension-1:0] hv;
    int unsigned            flips;
    hv = '0;
    for (int unsigned j = 0; j < NumChunks; j++) hv = (hv << SeedWidth) | HVDimension'(seed);
    flips = (32'(addr) * (HVDimension / 2)) / NumTotIm;
    return hv ^ ~({HVDimension{1'b1}} << flips);
  endfunction

  function automatic logic [PtrWidth-1:0] ptr_inc(logic [PtrWidth-1:0] ptr);
    return (ptr == PtrWidth'(HoldFifoDepth - 1)) ? '0 : ptr + PtrWidth'(1);
  endfunction

  logic [NumPorts-1:0][HVDimension-1:0]   w_im_hv;
  logic [NumPorts/2-1:0][HVDimension-1:0] w_cim_hv;

  for (genvar k = 0; k < NumPorts / 2; k++) begin : g_item_memory
    assign w_im_hv[2*k]   = project_hv(lowdim_data_i[2*k], im_seed_hv_i);
    assign w_im_hv[2*k+1] = project_hv(lowdim_data_i[2*k+1], im_seed_hv_i);
    assign w_cim_hv[k]    = cim_hv(lowdim_data_i[2*k], cim_seed_hv_i);
  end

  for (genvar p = 0; p < NumPorts; p++) begin : g_chan
    logic [HVDimension-1:0] r_mem [HoldFifoDepth];
    logic [PtrWidth-1:0]    r_rd_ptr, r_wr_ptr;
    logic [CntWidth-1:0]    r_count;
    logic                   w_push, w_pop, w_cim_sel;
    logic [HVDimension-1:0] w_push_hv;

    if (p % 2 == 0) begin : g_even
      assign w_cim_sel = (port_mode_i[p] == 2'd1);
    end else begin : g_odd
      assign w_cim_sel = 1'b0;
    end

    assign w_push_hv = (port_mode_i[p] == 2'd2) ? highdim_data_i[p] :
                       w_cim_sel                ? w_cim_hv[p/2]      : w_im_hv[p];

    assign im_valid_o[p]      = (r_count != '0);
    assign im_data_ready_o[p] = enable_i && !clr_i && (r_count < CntWidth'(HoldFifoDepth));
    assign w_push             = im_data_valid_i[p] && im_data_ready_o[p];
    assign w_pop              = im_pop_i[p] && im_valid_o[p];
    assign im_o[p]            = im_valid_o[p] ? r_mem[r_rd_ptr] : '0;
    assign fifo_count_o[p]    = r_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else if (clr_i) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
        if (w_push && !w_pop)      r_count <= r_count + CntWidth'(1);
        else if (w_pop && !w_push) r_count <= r_count - CntWidth'(1);
      end
    end

    // Storage needs no reset: r_count gates visibility of every entry.
    always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= w_push_hv;
    end
  end

  assign stall_o = |(im_pop_i & ~im_valid_o);

`ifdef IM_STALL_COUNTER_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (clr_i) begin
      r_stall_cnt <= '0;
    end else if (stall_o && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
